survivor_traceback_unit: RTL and testbench
==========================================

# survivor_traceback_unit

Survivor-path memory and traceback stage of the 4-state, rate-1/2, K=3 Viterbi decoder; sits directly downstream of `Add_compare_select_unit`. Each accepted cycle it stores the four ACS decision bits. On a full block it also captures the minimum-metric state. It then walks the trellis backwards and emits the decoded bits in chronological order. Block-based, non-overlapping: upstream is stalled via `o_ready` during traceback and output.

## Interface
- `SIZE_DATA`, 2: path-metric width, matching `Path_metric_unit`.
- `TB_DEPTH`, 16: decisions per block (power of two, 4..64); also the decoded bits per block.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  decision vector and metrics valid this cycle.
- `o_ready`  out  1  block accepts `i_valid` this cycle.
- `i_dec`  in  4  ACS decisions; `i_dec[s]`=1 means new state s chose its second candidate (odd predecessor).
- `i_PM_0..i_PM_3`  in  SIZE_DATA each  new path metrics produced in the same cycle as `i_dec`.
- `o_bit`  out  1  decoded information bit.
- `o_bit_valid`  out  1  `o_bit` valid.
- `o_bit_last`  out  1  final bit of the current block.

## Operation
- Trellis (fixed): the predecessor of state s is `{s[0], i_dec[s]}`. The decoded bit for a transition into s is `s[1]`.
- FSM states: FILL, TRACE, OUTPUT.
- FILL (`o_ready`=1):
  - On `i_valid`, write `i_dec` to `mem[wr_ptr]` and increment `wr_ptr`.
  - On the write to entry TB_DEPTH-1, latch the start state: argmin of `i_PM_0..3`, lowest index wins ties. Clear `wr_ptr` and go to TRACE.
- TRACE (`o_ready`=0): `rd_ptr` runs TB_DEPTH-1 down to 0, one step per cycle.
  - `obuf[rd_ptr] <= cur[1]`.
  - `cur <= {cur[0], mem[rd_ptr][cur]}`.
  - After the step at `rd_ptr`=0, go to OUTPUT.
- OUTPUT (`o_ready`=0):
  - Emit `obuf[0..TB_DEPTH-1]`, one bit per cycle with `o_bit_valid`=1.
  - `o_bit_last`=1 on index TB_DEPTH-1.
  - Then return to FILL.
- `i_valid` while `o_ready`=0 is ignored. Nothing is written and no error is raised; upstream must gate `Path_metric_unit` `i_valid` with `o_ready`.
- Metric comparison is unsigned, SIZE_DATA bits, no arithmetic (saturation is done upstream).

## Timing
- Reset values:
  - `o_ready`=0 while `i_rst` is high, 1 from the first cycle after.
  - `o_bit`=0, `o_bit_valid`=0, `o_bit_last`=0.
  - FSM=FILL; `wr_ptr`, `rd_ptr` and the start state are 0.
  - `mem` and `obuf` are not reset.
- Last block write at edge N: TRACE occupies cycles N+1..N+TB_DEPTH. Outputs are registered and valid on cycles N+TB_DEPTH+1..N+2·TB_DEPTH. `o_ready`=1 from cycle N+2·TB_DEPTH+1.
- Maximum throughput: TB_DEPTH bits per 3·TB_DEPTH cycles.
- `wr_ptr` wraps only at the block boundary; no partial blocks exist.
- Reset mid-TRACE or mid-OUTPUT aborts immediately: outputs drop to 0 the next cycle, and the partial block is discarded, not emitted.
- `i_rst` and `i_valid` high together: reset wins and nothing is written.

## Configuration
- `TB_ZERO_TAIL_EN` defined: traceback always starts from state 0 (zero-terminated frames). The `i_PM_*` inputs are unused and the argmin logic is not built.
- `TB_ZERO_TAIL_EN` undefined: start state is the argmin of the latched metrics as described above.

## Structure
- `viterbi_pkg`:
  - `NUM_STATES`=4 and the `state_t` (logic [1:0]) typedef.
  - `tb_fsm_e` enum {FILL, TRACE, OUTPUT}.
  - `pred_state(s, dec)` function.
- Sub-module `min_state_select`: combinational argmin over four SIZE_DATA metrics with lowest-index tie-break. Instantiated only when `TB_ZERO_TAIL_EN` is undefined.

## Test plan
- All-zero stream: 16 valid cycles with `i_dec`=4'b0000, `i_PM_0`=0, others 3 -> 16 bits of 0. `o_bit_last` on the 16th; `o_ready` low for exactly 32 cycles.
- All-ones stream: `i_dec`=4'b1000, `i_PM_3`=0, others 3 -> start state 3, 16 bits of 1.
- Tie-break: final `i_PM_0..3`=2,1,1,3 -> start state 1. First traced bit (block index 15) = 0. Under `TB_ZERO_TAIL_EN`, start state is 0 regardless of PMs.
- Backpressure: hold `i_valid`=1 continuously for 48 cycles -> only cycles with `o_ready`=1 write. Exactly 16 bits out per block, bit order matches the reference model.
- Reset mid-OUTPUT: assert `i_rst` after the 5th output bit -> `o_bit_valid`=0 next cycle. `o_ready`=1 after release. The next full block decodes correctly.
- Random encoder: random 16-bit info blocks through a K=3 (7,5) encoder model, BMU, ACSU and PMU with zero noise -> decoded bits equal the info bits.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and trellis helper for the 4-state, K=3 Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned NUM_STATES = 4;

  typedef logic [1:0] state_t;

  typedef enum logic [1:0] {
    FILL,
    TRACE,
    OUTPUT
  } tb_fsm_e;

  // The predecessor shares its high bit with the new state's low bit; the ACS decision supplies the rest.
  function automatic state_t pred_state(input state_t s, input logic [NUM_STATES-1:0] dec);
    return {s[0], dec[s]};
  endfunction

endpackage

// File: rtl/min_state_select.sv
// Combinational argmin over four path metrics.
// On a tie, the lowest state index wins.
module min_state_select
  import viterbi_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 2
) (
  input  logic [SIZE_DATA-1:0] i_pm_0,
  input  logic [SIZE_DATA-1:0] i_pm_1,
  input  logic [SIZE_DATA-1:0] i_pm_2,
  input  logic [SIZE_DATA-1:0] i_pm_3,
  output state_t               o_state
);

  logic                 w_lo_sel;
  logic                 w_hi_sel;
  logic [SIZE_DATA-1:0] w_lo_min;
  logic [SIZE_DATA-1:0] w_hi_min;

  // Strict less-than at every stage keeps the lower index on equality.
  assign w_lo_sel = (i_pm_1 < i_pm_0);
  assign w_hi_sel = (i_pm_3 < i_pm_2);
  assign w_lo_min = w_lo_sel ? i_pm_1 : i_pm_0;
  assign w_hi_min = w_hi_sel ? i_pm_3 : i_pm_2;

  assign o_state = (w_hi_min < w_lo_min) ? {1'b1, w_hi_sel} : {1'b0, w_lo_sel};

endmodule

// File: rtl/survivor_traceback_unit.sv
// Survivor memory and block traceback for the 4-state Viterbi decoder.
// Defining TB_ZERO_TAIL_EN makes traceback always start from state 0, and the metric inputs are then ignored.
module survivor_traceback_unit
  import viterbi_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 2,
  parameter int unsigned TB_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NUM_STATES-1:0] i_dec,
  input  logic [SIZE_DATA-1:0]  i_PM_0,
  input  logic [SIZE_DATA-1:0]  i_PM_1,
  input  logic [SIZE_DATA-1:0]  i_PM_2,
  input  logic [SIZE_DATA-1:0]  i_PM_3,
  output logic                  o_bit,
  output logic                  o_bit_valid,
  output logic                  o_bit_last
);

  localparam int unsigned      PtrW    = $clog2(TB_DEPTH);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(TB_DEPTH - 1);

  tb_fsm_e                 r_state;
  tb_fsm_e                 w_state_next;
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW-1:0]         r_rd_ptr;
  state_t                  r_cur;
  state_t                  w_start;
  logic                    w_wr_en;
  logic [NUM_STATES-1:0]   r_mem [TB_DEPTH];
  logic [TB_DEPTH-1:0]     r_obuf;

`ifdef TB_ZERO_TAIL_EN
  logic w_pm_unused;
  assign w_pm_unused = ^{i_PM_0, i_PM_1, i_PM_2, i_PM_3};
  assign w_start     = '0;
`else
  min_state_select #(
    .SIZE_DATA(SIZE_DATA)
  ) u_min_state_select (
    .i_pm_0 (i_PM_0),
    .i_pm_1 (i_PM_1),
    .i_pm_2 (i_PM_2),
    .i_pm_3 (i_PM_3),
    .o_state(w_start)
  );
`endif

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    unique case (r_state)
      FILL: begin
        if (i_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == LastIdx) w_state_next = TRACE;
        end
      end
      TRACE:   if (r_rd_ptr == '0) w_state_next = OUTPUT;
      OUTPUT:  if (r_rd_ptr == LastIdx) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  // rd_ptr counts down during TRACE, holds at 0, then counts back up to index obuf in OUTPUT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cur    <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        FILL: begin
          if (w_wr_en) begin
            if (r_wr_ptr == LastIdx) begin
              r_wr_ptr <= '0;
              r_rd_ptr <= LastIdx;
              r_cur    <= w_start;
            end else begin
              r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
          end
        end
        TRACE: begin
          r_cur <= pred_state(r_cur, r_mem[r_rd_ptr]);
          if (r_rd_ptr != '0) r_rd_ptr <= r_rd_ptr - PtrW'(1);
        end
        OUTPUT:  if (r_rd_ptr != LastIdx) r_rd_ptr <= r_rd_ptr + PtrW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_rst) r_mem[r_wr_ptr] <= i_dec;
    if ((r_state == TRACE) && !i_rst) r_obuf[r_rd_ptr] <= r_cur[1];
  end

  assign o_ready     = (r_state == FILL) && !i_rst;
  assign o_bit_valid = (r_state == OUTPUT);
  assign o_bit       = o_bit_valid && r_obuf[r_rd_ptr];
  assign o_bit_last  = o_bit_valid && (r_rd_ptr == LastIdx);

endmodule

// File: tb/tb_survivor_traceback_unit.sv
// Randomized self-checking bench for survivor_traceback_unit against a trellis reference model.
module tb_survivor_traceback_unit;

  localparam int unsigned D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic       rdy;
  logic [3:0] dec;
  logic [1:0] pm0, pm1, pm2, pm3;
  logic       obit, obv, obl;

  int n_checks = 0;
  int n_errors = 0;

  logic       got_bit [$];
  logic       got_last [$];

  logic [3:0] blk_dec [D];
  logic [1:0] blk_pm [D][4];
  logic       exp_bits [D];

  logic [1:0] acs_pm [4];
  logic       enc_u1, enc_u2;

  always #5 clk = ~clk;

  survivor_traceback_unit #(
    .SIZE_DATA(2),
    .TB_DEPTH (D)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (vld),
    .o_ready    (rdy),
    .i_dec      (dec),
    .i_PM_0     (pm0),
    .i_PM_1     (pm1),
    .i_PM_2     (pm2),
    .i_PM_3     (pm3),
    .o_bit      (obit),
    .o_bit_valid(obv),
    .o_bit_last (obl)
  );

  always @(negedge clk) begin
    if (obv) begin
      got_bit.push_back(obit);
      got_last.push_back(obl);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int ref_start();
    int best;
    best = 0;
`ifndef TB_ZERO_TAIL_EN
    for (int s = 1; s < 4; s++) if (blk_pm[D-1][s] < blk_pm[D-1][best]) best = s;
`endif
    return best;
  endfunction

  // Walk the trellis backwards from the start state using the stored decisions.
  task automatic ref_trace();
    logic [1:0] st;
    st = 2'(ref_start());
    for (int k = D - 1; k >= 0; k--) begin
      exp_bits[k] = st[1];
      st = {st[0], blk_dec[k][st]};
    end
  endtask

  task automatic rand_block();
    for (int i = 0; i < D; i++) begin
      blk_dec[i] = 4'($urandom);
      for (int s = 0; s < 4; s++) blk_pm[i][s] = 2'($urandom);
    end
  endtask

  task automatic drive(input int i);
    dec = blk_dec[i];
    pm0 = blk_pm[i][0];
    pm1 = blk_pm[i][1];
    pm2 = blk_pm[i][2];
    pm3 = blk_pm[i][3];
  endtask

  task automatic feed_block(input string tag);
    int t;
    for (int i = 0; i < D; i++) begin
      t = 0;
      while (!rdy && t < 200) begin
        tick();
        t++;
      end
      if (t >= 200) begin
        check({tag, "_ready_timeout"}, 0, 1);
        vld = 1'b0;
        return;
      end
      vld = 1'b1;
      drive(i);
      tick();
    end
    vld = 1'b0;
    dec = 4'($urandom);
  endtask

  task automatic wait_ready(input string tag);
    int lo;
    lo = 0;
    while (!rdy && lo < 200) begin
      lo++;
      tick();
    end
    check({tag, "_ready_low"}, lo, 2 * D);
  endtask

  task automatic check_bits(input string tag);
    check({tag, "_nbits"}, got_bit.size(), D);
    for (int k = 0; k < D && k < got_bit.size(); k++) begin
      check($sformatf("%s_bit%0d", tag, k), got_bit[k], exp_bits[k]);
      check($sformatf("%s_last%0d", tag, k), got_last[k], (k == D - 1));
    end
    got_bit.delete();
    got_last.delete();
  endtask

  task automatic run_block(input string tag);
    feed_block(tag);
    wait_ready(tag);
    tick();
    check_bits(tag);
  endtask

  // Noise-free (7,5) encoder feeding an ideal ACS with saturating 2-bit metrics.
  task automatic acs_step(input logic u, output logic [3:0] d);
    logic [1:0] rx;
    logic [1:0] e;
    logic [1:0] npm [4];
    int         c [2];
    int         p;
    rx = {u ^ enc_u1 ^ enc_u2, u ^ enc_u2};
    enc_u2 = enc_u1;
    enc_u1 = u;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 2; b++) begin
        p = (s % 2) * 2 + b;
        e = {1'(s / 2) ^ 1'(s % 2) ^ 1'(b), 1'(s / 2) ^ 1'(b)};
        c[b] = int'(acs_pm[p]) + $countones(rx ^ e);
        if (c[b] > 3) c[b] = 3;
      end
      d[s] = (c[1] < c[0]);
      npm[s] = d[s] ? 2'(c[1]) : 2'(c[0]);
    end
    for (int s = 0; s < 4; s++) acs_pm[s] = npm[s];
  endtask

  initial begin
    logic info [D];
    logic [3:0] dv;
    int t;

    rst = 1'b1;
    vld = 1'b1;
    dec = 4'hF;
    {pm0, pm1, pm2, pm3} = '0;
    tick();
    check("rst_ready", rdy, 0);
    check("rst_valid", obv, 0);
    tick();
    rst = 1'b0;
    vld = 1'b0;
    tick();
    check("post_rst_ready", rdy, 1);
    check("post_rst_valid", obv, 0);
    check("post_rst_bit", obit, 0);
    check("post_rst_last", obl, 0);

    for (int i = 0; i < D; i++) begin
      blk_dec[i] = 4'b0000;
      blk_pm[i][0] = 2'd0; blk_pm[i][1] = 2'd3; blk_pm[i][2] = 2'd3; blk_pm[i][3] = 2'd3;
    end
    ref_trace();
    run_block("zeros");

    for (int i = 0; i < D; i++) begin
      blk_dec[i] = 4'b1000;
      blk_pm[i][0] = 2'd3; blk_pm[i][1] = 2'd3; blk_pm[i][2] = 2'd3; blk_pm[i][3] = 2'd0;
    end
    ref_trace();
    run_block("ones");

    rand_block();
    blk_pm[D-1][0] = 2'd2; blk_pm[D-1][1] = 2'd1; blk_pm[D-1][2] = 2'd1; blk_pm[D-1][3] = 2'd3;
    ref_trace();
    run_block("tie");

    for (int b = 0; b < 6; b++) begin
      rand_block();
      ref_trace();
      run_block($sformatf("rand%0d", b));
    end

    // Valid held high across the whole block period; only the FILL cycles may write.
    rand_block();
    ref_trace();
    for (int c = 0; c < 3 * D; c++) begin
      check($sformatf("bp_ready%0d", c), rdy, (c < D));
      vld = 1'b1;
      if (c < D) drive(c);
      else begin
        dec = 4'($urandom);
        {pm0, pm1, pm2, pm3} = 8'($urandom);
      end
      tick();
    end
    vld = 1'b0;
    check("bp_ready_end", rdy, 1);
    check_bits("bp");
    rand_block();
    ref_trace();
    run_block("bp_next");

    rand_block();
    ref_trace();
    feed_block("rstmid");
    t = 0;
    while (got_bit.size() < 5 && t < 200) begin
      tick();
      t++;
    end
    check("rstmid_five_bits", got_bit.size(), 5);
    rst = 1'b1;
    tick();
    check("rstmid_valid", obv, 0);
    check("rstmid_bit", obit, 0);
    check("rstmid_last", obl, 0);
    check("rstmid_ready_in_rst", rdy, 0);
    rst = 1'b0;
    tick();
    check("rstmid_ready", rdy, 1);
    repeat (3) tick();
    check("rstmid_no_more_bits", got_bit.size(), 5);
    got_bit.delete();
    got_last.delete();
    rand_block();
    ref_trace();
    run_block("rstmid_next");

    acs_pm[0] = 2'd0; acs_pm[1] = 2'd3; acs_pm[2] = 2'd3; acs_pm[3] = 2'd3;
    enc_u1 = 1'b0;
    enc_u2 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < D; i++) info[i] = 1'($urandom);
`ifdef TB_ZERO_TAIL_EN
      info[D-2] = 1'b0;
      info[D-1] = 1'b0;
`endif
      for (int i = 0; i < D; i++) begin
        acs_step(info[i], dv);
        blk_dec[i] = dv;
        for (int s = 0; s < 4; s++) blk_pm[i][s] = acs_pm[s];
        exp_bits[i] = info[i];
      end
      run_block($sformatf("enc%0d", b));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
